// File: rtl/unfold_serializer.sv
`default_nettype none
// ============================================================================
// Module   : unfold_serializer
// Purpose  : Converts L-lane sample blocks from an unfolded IIR filter into a
//            serial stream. Up to DEPTH blocks are buffered in a circular
//            buffer. Each block is emitted one sample per cycle under a
//            valid/ready handshake. Every block carries its own lane-order
//            reversal flag.
// Ports    : CLK      - clock, rising edge
//            RST_n    - synchronous reset, ACTIVE-HIGH (1 resets)
//            DIN      - input block, lane k at DIN[k*NBIT +: NBIT], lane 0 oldest
//            VIN      - DIN valid
//            REV      - per-block flag, 1 = emit lanes LANES-1..0
//            RDY_IN   - buffer can accept a block this cycle
//            DOUT     - current serial sample (0 when VOUT=0)
//            VOUT     - DOUT valid
//            RDY_OUT  - downstream ready
//            FILL     - blocks held, including the partially emitted block
//            OVF      - sticky, set when a block was offered while full
//            SCNT     - samples transferred since reset, wraps at 2^32
// Revision : 1.0 - initial release
// ============================================================================
module unfold_serializer #(
  parameter int NBIT  = 16,
  parameter int LANES = 3,
  parameter int DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         RST_n,
  input  logic [LANES*NBIT-1:0]        DIN,
  input  logic                         VIN,
  input  logic                         REV,
  output logic                         RDY_IN,
  output logic [NBIT-1:0]              DOUT,
  output logic                         VOUT,
  input  logic                         RDY_OUT,
  output logic [$clog2(DEPTH+1)-1:0]   FILL,
  output logic                         OVF,
  output logic [31:0]                  SCNT
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(LANES);
  localparam int FW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] C_LAST_LANE = LW'(LANES-1);
  localparam logic [FW-1:0] C_FULL      = FW'(DEPTH);

  // Block storage. There is no reset on the contents because only the
  // pointers and FILL decide what is valid.
  logic [LANES*NBIT-1:0] mem_q [DEPTH];
  logic                  rev_mem_q [DEPTH];

  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [LW-1:0] li_q, li_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   scnt_q, scnt_d;

  logic          rdy_in;
  logic          vout;
  logic          wr;
  logic          xfer;
  logic          rel;
  logic [LANES*NBIT-1:0] head;
  logic          head_rev;
  logic [LW-1:0] sel;
  logic [NBIT-1:0] dout;

  // RDY_IN depends only on registered state. When the buffer is full, a block
  // is refused even if the head block is released in the same cycle.
  assign rdy_in   = (fill_q != C_FULL);
  assign vout     = (fill_q != '0);
  assign wr       = VIN && rdy_in && !RST_n;
  assign xfer     = vout && RDY_OUT;
  assign rel      = xfer && (li_q == C_LAST_LANE);

  assign head     = mem_q[rp_q];
  assign head_rev = rev_mem_q[rp_q];
  assign sel      = head_rev ? (C_LAST_LANE - li_q) : li_q;

  always_comb begin
    dout = '0;
    if (vout) begin
      for (int k = 0; k < LANES; k++) begin
        if (sel == LW'(k)) dout = head[k*NBIT +: NBIT];
      end
    end
  end

  always_comb begin
    wp_d   = wp_q;
    rp_d   = rp_q;
    li_d   = li_q;
    fill_d = fill_q;
    ovf_d  = ovf_q;
    scnt_d = scnt_q;

    if (wr) wp_d = wp_q + 1'b1;
    if (VIN && !rdy_in) ovf_d = 1'b1;

    if (xfer) begin
      scnt_d = scnt_q + 32'd1;
      if (li_q == C_LAST_LANE) begin
        li_d = '0;
        rp_d = rp_q + 1'b1;
      end else begin
        li_d = li_q + 1'b1;
      end
    end

    if (wr && !rel)      fill_d = fill_q + 1'b1;
    else if (rel && !wr) fill_d = fill_q - 1'b1;

    if (RST_n) begin
      wp_d   = '0;
      rp_d   = '0;
      li_d   = '0;
      fill_d = '0;
      ovf_d  = 1'b0;
      scnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    wp_q   <= wp_d;
    rp_q   <= rp_d;
    li_q   <= li_d;
    fill_q <= fill_d;
    ovf_q  <= ovf_d;
    scnt_q <= scnt_d;
  end

  always_ff @(posedge CLK) begin
    if (wr) begin
      mem_q[wp_q]     <= DIN;
      rev_mem_q[wp_q] <= REV;
    end
  end

  assign RDY_IN = rdy_in;
  assign VOUT   = vout;
  assign DOUT   = dout;
  assign FILL   = fill_q;
  assign OVF    = ovf_q;
  assign SCNT   = scnt_q;

endmodule
`default_nettype wire

// File: tb/tb_unfold_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_unfold_serializer
// Purpose  : Self-checking bench for unfold_serializer (NBIT=16, LANES=3,
//            DEPTH=4). A reference model tracks the expected serial samples
//            and the expected FILL, OVF and SCNT values. It also checks every
//            DUT output once per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unfold_serializer;

  localparam int NBIT  = 16;
  localparam int LANES = 3;
  localparam int DEPTH = 4;
  localparam int FW    = $clog2(DEPTH+1);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [LANES*NBIT-1:0] din = '0;
  logic                  vin = 1'b0;
  logic                  rev = 1'b0;
  logic                  rdy_in;
  logic [NBIT-1:0]       dout;
  logic                  vout;
  logic                  rdy_out = 1'b1;
  logic [FW-1:0]         fill;
  logic                  ovf;
  logic [31:0]           scnt;

  unfold_serializer #(.NBIT(NBIT), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .CLK(clk), .RST_n(rst), .DIN(din), .VIN(vin), .REV(rev),
    .RDY_IN(rdy_in), .DOUT(dout), .VOUT(vout), .RDY_OUT(rdy_out),
    .FILL(fill), .OVF(ovf), .SCNT(scnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model. It holds the samples still to be emitted, in output order.
  logic [NBIT-1:0] q[$];
  logic            m_ovf  = 1'b0;
  logic [31:0]     m_scnt = '0;
  logic            mon_en = 1'b0;

  function automatic int m_fill();
    return (q.size() + LANES - 1) / LANES;
  endfunction

  // Outputs are compared at negedge, when they are stable. The model then
  // advances to the state that the next posedge will produce.
  always @(negedge clk) begin
    if (mon_en) begin
      logic m_rdy;
      logic m_vout;
      m_rdy  = (m_fill() != DEPTH);
      m_vout = (q.size() != 0);
      chk("vout",   32'(vout),   32'(m_vout));
      chk("rdy_in", 32'(rdy_in), 32'(m_rdy));
      chk("fill",   32'(fill),   32'(m_fill()));
      chk("ovf",    32'(ovf),    32'(m_ovf));
      chk("scnt",   scnt,        m_scnt);
      chk("dout",   32'(dout),   m_vout ? 32'(q[0]) : 32'd0);

      if (rst) begin
        q.delete();
        m_ovf  = 1'b0;
        m_scnt = '0;
      end else begin
        if (m_vout && rdy_out) begin
          void'(q.pop_front());
          m_scnt = m_scnt + 32'd1;
        end
        if (vin && m_rdy) begin
          for (int i = 0; i < LANES; i++) begin
            int idx;
            idx = rev ? (LANES - 1 - i) : i;
            q.push_back(din[idx*NBIT +: NBIT]);
          end
        end else if (vin) begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [LANES*NBIT-1:0] blk(input int a, input int b, input int c);
    return {16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic send(input logic [LANES*NBIT-1:0] d, input logic r);
    din = d;
    rev = r;
    vin = 1'b1;
    cyc();
    vin = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    cyc();
    mon_en = 1'b1;
    cyc();
    rst = 1'b0;

    // Single block in lane order
    send(blk(1, 2, 3), 1'b0);
    cyc(4);
    chk("t1_scnt", scnt, 32'd3);
    chk("t1_fill", 32'(fill), 32'd0);

    // Reversed block, then a normal block straight after it
    send(blk(1, 2, 3), 1'b1);
    send(blk(16'h11, 16'h12, 16'h13), 1'b0);
    cyc(8);

    // Stall: fill to four blocks, then drop a fifth block
    rdy_out = 1'b0;
    for (int b = 0; b < 5; b++) send(blk(16'h100 + 3*b, 16'h101 + 3*b, 16'h102 + 3*b), b[0]);
    chk("t3_fill", 32'(fill), 32'd4);
    chk("t3_ovf", 32'(ovf), 32'd1);
    chk("t3_rdy", 32'(rdy_in), 32'd0);
    cyc(3);
    rdy_out = 1'b1;
    cyc(14);

    // A block offered while full is refused, even when the head is released
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    rdy_out = 1'b0;
    for (int b = 0; b < 4; b++) send(blk(16'h200 + 3*b, 16'h201 + 3*b, 16'h202 + 3*b), 1'b0);
    rdy_out = 1'b1;
    cyc(2);
    send(blk(16'hBAD0, 16'hBAD1, 16'hBAD2), 1'b0);
    chk("t4_ovf", 32'(ovf), 32'd1);
    chk("t4_rdy", 32'(rdy_in), 32'd1);
    send(blk(16'h300, 16'h301, 16'h302), 1'b0);
    cyc(14);

    // Sustained ramp, one block every LANES cycles
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int b = 0; b < 100; b++) begin
      send(blk(3*b, 3*b + 1, 3*b + 2), 1'b0);
      cyc(2);
    end
    cyc(4);
    chk("t5_scnt", scnt, 32'd300);
    chk("t5_ovf", 32'(ovf), 32'd0);

    // Mid-stream reset with FILL=2 and li=1
    rdy_out = 1'b0;
    send(blk(16'h400, 16'h401, 16'h402), 1'b0);
    send(blk(16'h403, 16'h404, 16'h405), 1'b0);
    rdy_out = 1'b1;
    cyc();
    chk("t6_pre_fill", 32'(fill), 32'd2);
    rst = 1'b1;
    din = blk(16'hDEAD, 16'hDEAD, 16'hDEAD);
    vin = 1'b1;
    cyc();
    vin = 1'b0;
    rst = 1'b0;
    chk("t6_vout", 32'(vout), 32'd0);
    chk("t6_fill", 32'(fill), 32'd0);
    chk("t6_scnt", scnt, 32'd0);
    send(blk(16'h500, 16'h501, 16'h502), 1'b0);
    chk("t6_first", 32'(dout), 32'h500);
    cyc(5);
    chk("end_empty", 32'(q.size()), 32'd0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
